// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// load funct3 codes, store size codes and store lane helpers.
package data_mem_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Load funct3 codes (MEM_READ[2:0]); 011/110/111 fall through to word
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store size codes (MEM_WRITE[1:0]); 11 falls through to word
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   function automatic logic [3:0] store_be(input logic [1:0] size,
                                           input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << offset;
         SZ_H:    be = 4'b0011 << {offset[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                               input logic [31:0] data);
      logic [31:0] lanes;
      case (size)
         SZ_B:    lanes = {4{data[7:0]}};
         SZ_H:    lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/data_mem_controller_load_aligner.sv
// load_aligner: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it to 32 bits.
// Ports:
//   rdata  in  32  word returned by the backing memory
//   offset in  2   byte offset of the load address
//   funct3 in  3   load funct3 code
//   result out 32  extended load value
module load_aligner
   import data_mem_controller_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      // halves ignore offset[0]: an odd half address reads the containing half
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'h0, byte_sel};
         F3_LHU:  result = {16'h0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: MEM-stage responder that turns a load/store request
// into one word-wide REQ/ACK transaction on the backing memory and returns an
// aligned, extended load result. BUSY stalls the pipeline meanwhile.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses skip the memory
// and pulse MISALIGNED instead.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   MEM_READ[3:0]         [3] load enable, [2:0] funct3
//   MEM_WRITE[2:0]        [2] store enable, [1:0] size
//   ADDRESS, WRITE_DATA   request address and store data
//   READ_DATA, BUSY       load result and pipeline stall
//   MEM_REQ/WE/ADDR/BE/WDATA/RDATA/ACK   backing-memory port
//   MISALIGNED            (MISALIGN_TRAP_EN only) misalignment pulse
//
// state   | meaning
// IDLE    | waiting for a request; BUSY follows the enables combinationally
// WAIT    | MEM_REQ held with stable command until MEM_ACK
// DONE    | one-cycle release; stalled instruction still presented, ignored
module data_mem_controller
   import data_mem_controller_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 32,
   parameter logic [31:0] RESET_RDATA = 32'h0
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [3:0]            MEM_READ,
   input  logic [2:0]            MEM_WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [31:0]           WRITE_DATA,
   output logic [31:0]           READ_DATA,
   output logic                  BUSY,
   output logic                  MEM_REQ,
   output logic                  MEM_WE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [3:0]            MEM_BE,
   output logic [31:0]           MEM_WDATA,
   input  logic [31:0]           MEM_RDATA,
   input  logic                  MEM_ACK
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  MISALIGNED
`endif
);

   state_t      state;
   logic        req_load;
   logic        req_store;
   logic        req_any;
   logic [1:0]  offset_q;
   logic [2:0]  funct3_q;
   logic [31:0] load_result;

   assign req_load  = MEM_READ[3];
   assign req_store = MEM_WRITE[2];
   assign req_any   = req_load | req_store;

   assign BUSY = !RESET && ((state == ST_IDLE && req_any) || state == ST_WAIT);

`ifdef MISALIGN_TRAP_EN
   logic misalign_req;

   // store wins when both enables are set, so its size decides alignment
   always_comb begin
      misalign_req = 1'b0;
      if (req_store) begin
         case (MEM_WRITE[1:0])
            SZ_B:    misalign_req = 1'b0;
            SZ_H:    misalign_req = ADDRESS[0];
            default: misalign_req = |ADDRESS[1:0];
         endcase
      end else if (MEM_READ[1]) begin
         misalign_req = |ADDRESS[1:0];
      end else if (MEM_READ[0]) begin
         misalign_req = ADDRESS[0];
      end
   end
`endif

   load_aligner u_load_aligner (
      .rdata  (MEM_RDATA),
      .offset (offset_q),
      .funct3 (funct3_q),
      .result (load_result)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         MEM_REQ   <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_BE    <= 4'b0000;
         MEM_WDATA <= 32'h0;
         READ_DATA <= RESET_RDATA;
         offset_q  <= 2'b00;
         funct3_q  <= 3'b000;
`ifdef MISALIGN_TRAP_EN
         MISALIGNED <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
`ifdef MISALIGN_TRAP_EN
                  if (misalign_req) begin
                     state      <= ST_DONE;
                     MISALIGNED <= 1'b1;
                  end else
`endif
                  begin
                     state    <= ST_WAIT;
                     MEM_REQ  <= 1'b1;
                     MEM_WE   <= req_store;
                     MEM_ADDR <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
                     offset_q <= ADDRESS[1:0];
                     funct3_q <= MEM_READ[2:0];
                     if (req_store) begin
                        MEM_BE    <= store_be(MEM_WRITE[1:0], ADDRESS[1:0]);
                        MEM_WDATA <= store_lanes(MEM_WRITE[1:0], WRITE_DATA);
                     end else begin
                        MEM_BE    <= 4'b0000;
                        MEM_WDATA <= 32'h0;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (MEM_ACK) begin
                  state   <= ST_DONE;
                  MEM_REQ <= 1'b0;
                  if (!MEM_WE) READ_DATA <= load_result;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
`ifdef MISALIGN_TRAP_EN
               MISALIGNED <= 1'b0;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
